// File: rtl/nfc_cmd_dispatch_if.sv
// Host-command and controller-command signals of the NAND command dispatcher.
// The slave modport is the dispatcher; the master modport is its environment (host and controller).
interface nfc_cmd_dispatch_if #(
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic          host_valid;
   logic          host_ready;
   logic [32:0]   host_cmd;
   logic [32:0]   nfc_cmd;
   logic          nfc_done;
   logic          host_done;
   logic          busy;
   logic [CW-1:0] fifo_count;

   modport master (
      output host_valid, host_cmd, nfc_done,
      input  host_ready, nfc_cmd, host_done, busy, fifo_count
   );

   modport slave (
      input  host_valid, host_cmd, nfc_done,
      output host_ready, nfc_cmd, host_done, busy, fifo_count
   );
endinterface

// File: rtl/nfc_cmd_dispatch.sv
// Buffers host transfer commands and feeds the NAND controller one block-bounded segment
// per done pulse, parking the controller on a harmless 1-byte read when there is no work.
module nfc_cmd_dispatch #(
   parameter int unsigned DEPTH      = 4,
   parameter logic [17:0] PARK_FADDR = 18'd0,
   parameter logic [6:0]  PARK_MADDR = 7'd127
) (
   input logic              clk,
   input logic              rst,
   nfc_cmd_dispatch_if.slave bus
);
   localparam int unsigned   AW       = $clog2(DEPTH);
   localparam int unsigned   CW       = AW + 1;
   localparam logic [CW-1:0] FULL     = CW'(DEPTH);
   localparam logic [32:0]   PARK_CMD = {1'b1, PARK_FADDR, PARK_MADDR, 7'd1};

   typedef enum logic [1:0] {ST_INIT, ST_PARK, ST_RUN} state_e;

   state_e        state_q, state_d;
   logic [32:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          cur_rw_q, cur_rw_d;
   logic [17:0]   cur_f_q, cur_f_d;
   logic [6:0]    cur_m_q, cur_m_d;
   logic [7:0]    rem_q, rem_d;
   logic          last_q, last_d;
   logic [32:0]   nfc_cmd_q, nfc_cmd_d;
   logic          host_done_q, host_done_d;

   logic          push, pop, use_cur;
   logic [32:0]   head;
   logic [7:0]    head_rem;
   logic          src_rw;
   logic [17:0]   src_f;
   logic [6:0]    src_m;
   logic [7:0]    src_rem;
   logic [11:0]   room;
   logic [7:0]    seg;
   logic [7:0]    rem_left;

   always_comb begin
      push     = bus.host_valid && (count_q != FULL);
      head     = mem_q[rd_ptr_q];
      head_rem = (head[6:0] == 7'd0) ? 8'd128 : {1'b0, head[6:0]};

      // A pending second segment takes priority over the FIFO head; the head stays queued
      // until its final segment is loaded, so both sources share one segment calculator.
      use_cur  = (rem_q != 8'd0);
      src_rw   = use_cur ? cur_rw_q : head[32];
      src_f    = use_cur ? cur_f_q  : head[31:14];
      src_m    = use_cur ? cur_m_q  : head[13:7];
      src_rem  = use_cur ? rem_q    : head_rem;

      room     = 12'd2048 - {1'b0, src_f[10:0]};
      seg      = ({4'd0, src_rem} < room) ? src_rem : room[7:0];
      rem_left = src_rem - seg;

      state_d     = state_q;
      cur_rw_d    = cur_rw_q;
      cur_f_d     = cur_f_q;
      cur_m_d     = cur_m_q;
      rem_d       = rem_q;
      last_d      = last_q;
      nfc_cmd_d   = nfc_cmd_q;
      host_done_d = 1'b0;
      pop         = 1'b0;

      if (bus.nfc_done) begin
         host_done_d = last_q;
         if (use_cur || (count_q != '0)) begin
            nfc_cmd_d = {src_rw, src_f, src_m, seg[6:0]};
            cur_rw_d  = src_rw;
            cur_f_d   = src_f + 18'(seg);
            cur_m_d   = src_m + seg[6:0];
            rem_d     = rem_left;
            last_d    = (rem_left == 8'd0);
            pop       = (rem_left == 8'd0);
            state_d   = ST_RUN;
         end else begin
            nfc_cmd_d = PARK_CMD;
            last_d    = 1'b0;
            state_d   = ST_PARK;
         end
      end

      wr_ptr_d = push ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
      rd_ptr_d = pop  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_INIT;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         cur_rw_q    <= 1'b0;
         cur_f_q     <= '0;
         cur_m_q     <= '0;
         rem_q       <= '0;
         last_q      <= 1'b0;
         nfc_cmd_q   <= PARK_CMD;
         host_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         cur_rw_q    <= cur_rw_d;
         cur_f_q     <= cur_f_d;
         cur_m_q     <= cur_m_d;
         rem_q       <= rem_d;
         last_q      <= last_d;
         nfc_cmd_q   <= nfc_cmd_d;
         host_done_q <= host_done_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= bus.host_cmd;
   end

   assign bus.host_ready = (count_q != FULL);
   assign bus.nfc_cmd    = nfc_cmd_q;
   assign bus.host_done  = host_done_q;
   assign bus.busy       = (state_q == ST_RUN) || (count_q != '0);
   assign bus.fifo_count = count_q;
endmodule
